// File: rtl/ins_memory_loadable.sv
// Loadable instruction memory: a byte-stream loader fills the word array from index 0,
// then the core fetches words by byte address with one-cycle latency.
//
// state  | meaning
// S_IDLE | out of reset, nothing loaded yet
// S_LOAD | assembling program bytes into words and writing them
// S_RUN  | programmed, serving fetches
module ins_memory_loadable #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEMORY_DEPTH      = 256,
  parameter int PC_WIDTH          = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h00000013
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            load_start,
  input  logic [7:0]                      load_data,
  input  logic                            load_data_valid,
  input  logic                            load_end,
  input  logic [PC_WIDTH-1:0]             pc,
  input  logic                            fetch_req,
  output logic [INSTRUCTION_WIDTH-1:0]    instruction,
  output logic                            instruction_valid,
  output logic                            fetch_error,
  output logic                            ready,
  output logic                            load_busy,
  output logic [$clog2(MEMORY_DEPTH):0]   load_words
);

  localparam int BYTES = INSTRUCTION_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int AW    = $clog2(MEMORY_DEPTH);
  localparam int BCW   = (OFF > 0) ? OFF : 1;
  localparam int LWW   = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
  // Output word source; ZERO keeps instruction at 0 from reset until the first fetch.
  typedef enum logic [1:0] {OUT_ZERO, OUT_MEM, OUT_NOP} out_sel_t;

  state_t                  state_q, state_d;
  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [INSTRUCTION_WIDTH-1:0] asm_q, asm_d;
  logic [LWW-1:0]          load_words_q, load_words_d;
  logic                    valid_q, valid_d;
  logic                    fetch_error_q, fetch_error_d;
  out_sel_t                out_sel_q, out_sel_d;

  logic [INSTRUCTION_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [INSTRUCTION_WIDTH-1:0] rd_data_q;
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [INSTRUCTION_WIDTH-1:0] mem_wdata;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;

  logic [PC_WIDTH-1:0]     word_idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    fetch_bad;
  logic                    fetch_go;
  logic                    full;
  logic                    at_last;
  logic                    partial;
  logic [INSTRUCTION_WIDTH-1:0] word;

  assign word_idx     = pc >> OFF;
  assign misaligned   = (pc & PC_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = word_idx >= PC_WIDTH'(MEMORY_DEPTH);
  assign fetch_bad    = misaligned | out_of_range;
  assign rd_addr      = word_idx[AW-1:0];
  assign full         = load_words_q >= LWW'(MEMORY_DEPTH);
  assign at_last      = load_words_q == LWW'(MEMORY_DEPTH - 1);
  assign mem_waddr    = load_words_q[AW-1:0];

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    load_words_d = load_words_q;
    mem_we       = 1'b0;
    word         = asm_q;
    mem_wdata    = asm_q;
    partial      = byte_cnt_q != '0;

    if (load_start) begin
      state_d      = S_LOAD;
      byte_cnt_d   = '0;
      asm_d        = '0;
      load_words_d = '0;
    end else if (state_q == S_LOAD) begin
      if (load_data_valid && !full) begin
        for (int i = 0; i < BYTES; i++) begin
          if (byte_cnt_q == BCW'(i)) word[8*i +: 8] = load_data;
        end
        if (byte_cnt_q == BCW'(BYTES - 1)) begin
          mem_we       = 1'b1;
          mem_wdata    = word;
          load_words_d = load_words_q + LWW'(1);
          byte_cnt_d   = '0;
          asm_d        = '0;
          partial      = 1'b0;
          if (at_last) state_d = S_RUN;
        end else begin
          asm_d      = word;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          partial    = 1'b1;
        end
      end
      if (load_end) begin
        state_d = S_RUN;
        // Upper lanes of a partial word are still zero since asm is cleared per word.
        if (partial && !full) begin
          mem_we       = 1'b1;
          mem_wdata    = word;
          load_words_d = load_words_q + LWW'(1);
          byte_cnt_d   = '0;
          asm_d        = '0;
        end
      end
    end
  end

  always_comb begin
    fetch_go      = (state_q == S_RUN) && fetch_req && !load_start;
    valid_d       = fetch_go;
    fetch_error_d = fetch_go && fetch_bad;
    rd_en         = fetch_go && !fetch_bad;
    out_sel_d     = out_sel_q;
    if (fetch_go) out_sel_d = fetch_bad ? OUT_NOP : OUT_MEM;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      load_words_q  <= '0;
      valid_q       <= 1'b0;
      fetch_error_q <= 1'b0;
      out_sel_q     <= OUT_ZERO;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      load_words_q  <= load_words_d;
      valid_q       <= valid_d;
      fetch_error_q <= fetch_error_d;
      out_sel_q     <= out_sel_d;
    end
  end

  // No reset on the array or its read register so the pair maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en)  rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    instruction = '0;
    case (out_sel_q)
      OUT_MEM: instruction = rd_data_q;
      OUT_NOP: instruction = NOP_INSTRUCTION;
      default: instruction = '0;
    endcase
  end

  assign instruction_valid = valid_q;
  assign fetch_error       = fetch_error_q;
  assign ready             = state_q == S_RUN;
  assign load_busy         = state_q == S_LOAD;
  assign load_words        = load_words_q;

endmodule

// File: tb/tb_ins_memory_loadable.sv
// Scoreboard bench for ins_memory_loadable: loads are modelled as plain byte lists packed
// into words, fetch expectations are queued and popped by an independent monitor.
module tb_ins_memory_loadable;
  localparam int DEPTH = 256;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rstN;
  logic        load_start, load_data_valid, load_end, fetch_req;
  logic [7:0]  load_data;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instruction_valid, fetch_error, ready, load_busy;
  logic [8:0]  load_words;

  ins_memory_loadable dut (
    .clk(clk), .rstN(rstN), .load_start(load_start), .load_data(load_data),
    .load_data_valid(load_data_valid), .load_end(load_end), .pc(pc), .fetch_req(fetch_req),
    .instruction(instruction), .instruction_valid(instruction_valid),
    .fetch_error(fetch_error), .ready(ready), .load_busy(load_busy), .load_words(load_words)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [DEPTH];
  int          exp_words;
  logic [31:0] exp_instr_q [$];
  bit          exp_err_q [$];
  int          checks = 0;
  int          errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!instruction_valid) begin
      check("error_without_valid", {63'd0, fetch_error}, 64'd0);
    end else if (exp_instr_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_valid: got valid=1 instr=%0h expected valid=0", instruction);
    end else begin
      check("fetch_instr", {32'd0, instruction}, {32'd0, exp_instr_q.pop_front()});
      check("fetch_error", {63'd0, fetch_error}, {63'd0, exp_err_q.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] p);
    bit err;
    pc        = p;
    fetch_req = 1'b1;
    err = (p % 4 != 0) || ((p / 4) >= DEPTH);
    exp_err_q.push_back(err);
    exp_instr_q.push_back(err ? NOP : ref_mem[p / 4]);
  endtask

  task automatic fetch(input logic [31:0] p);
    push_fetch(p);
    cyc();
    fetch_req = 1'b0;
  endtask

  // end_mode: 0 = load_end on its own cycle, 1 = with the last byte, 2 = no load_end
  task automatic do_load(input logic [7:0] bytes [$], input int end_mode, input bit fetch_on_start);
    int n;
    logic [31:0] w;
    load_start = 1'b1;
    if (fetch_on_start) begin
      pc        = 32'd0;
      fetch_req = 1'b1;
    end
    cyc();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("busy_after_start", {63'd0, load_busy}, 64'd1);
    check("ready_after_start", {63'd0, ready}, 64'd0);
    check("words_after_start", {55'd0, load_words}, 64'd0);
    for (int i = 0; i < bytes.size(); i++) begin
      load_data       = bytes[i];
      load_data_valid = 1'b1;
      load_end        = (end_mode == 1) && (i == bytes.size() - 1);
      cyc();
    end
    load_data_valid = 1'b0;
    load_end        = 1'b0;
    if (end_mode == 0) begin
      load_end = 1'b1;
      cyc();
      load_end = 1'b0;
    end
    n = (bytes.size() + 3) / 4;
    if (n > DEPTH) n = DEPTH;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < bytes.size()) w = w | (32'(bytes[4 * k + b]) << (8 * b));
      ref_mem[k] = w;
    end
    exp_words = n;
    check("ready_after_load", {63'd0, ready}, 64'd1);
    check("busy_after_load", {63'd0, load_busy}, 64'd0);
    check("load_words", {55'd0, load_words}, 64'(n));
  endtask

  task automatic rand_fetch();
    case ($urandom_range(0, 3))
      0: fetch({$urandom_range(0, 32'(DEPTH + 100)), 2'b00} | 32'($urandom_range(1, 3)));
      1: fetch(($urandom_range(DEPTH, 32'h3FFF_FFFF)) * 4);
      default: fetch(32'($urandom_range(0, exp_words - 1)) * 4);
    endcase
  endtask

  initial begin
    logic [7:0] bq [$];
    int len;
    rstN = 1'b0;
    load_start = 0; load_data = 0; load_data_valid = 0; load_end = 0; pc = 0; fetch_req = 0;
    #12;
    check("rst_instr", {32'd0, instruction}, 64'd0);
    check("rst_valid", {63'd0, instruction_valid}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd0);
    check("rst_busy", {63'd0, load_busy}, 64'd0);
    check("rst_words", {55'd0, load_words}, 64'd0);
    cyc();
    rstN = 1'b1;
    cyc();

    // fetch before any load gives nothing
    fetch_req = 1'b1; cyc(); cyc(); fetch_req = 1'b0;

    bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(bq, 0, 1'b0);
    push_fetch(32'd0); cyc();
    push_fetch(32'd4); cyc();
    fetch_req = 1'b0;
    cyc();

    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_load(bq, 1, 1'b0);
    fetch(32'd4);
    fetch(32'd0);
    fetch(32'd2);
    fetch(32'h400);
    fetch(32'hFFFF_FFFC);

    bq = {};
    for (int i = 0; i < 4 * DEPTH + 4; i++) bq.push_back(8'($urandom));
    do_load(bq, 2, 1'b0);
    fetch(32'h3FC);
    for (int i = 0; i < 20; i++) rand_fetch();

    // load_start beats a same-cycle fetch; word 1 keeps its streamed value
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(bq, 0, 1'b1);
    exp_words = DEPTH;
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'h3FC);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 23);
      bq = {};
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      do_load(bq, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 6; i++) rand_fetch();
    end

    // asynchronous reset in the middle of a word
    load_start = 1'b1; cyc(); load_start = 1'b0;
    load_data = 8'h5A; load_data_valid = 1'b1; cyc(); cyc(); load_data_valid = 1'b0;
    rstN = 1'b0;
    #1;
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_busy", {63'd0, load_busy}, 64'd0);
    check("midrst_words", {55'd0, load_words}, 64'd0);
    check("midrst_valid", {63'd0, instruction_valid}, 64'd0);
    check("midrst_instr", {32'd0, instruction}, 64'd0);
    cyc();
    rstN = 1'b1;
    cyc();
    pc = 32'd0; fetch_req = 1'b1; cyc(); cyc(); cyc(); fetch_req = 1'b0;
    bq = '{8'hDE, 8'hAD, 8'hBE};
    do_load(bq, 0, 1'b0);
    exp_words = 1;
    fetch(32'd0);
    fetch(32'd8);

    for (int i = 0; i < 10 && exp_instr_q.size() != 0; i++) cyc();
    check("scoreboard_drained", 64'(exp_instr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_memory_loadable.md
Name: ins_memory_loadable

Overview:
Parametrised instruction memory with a synchronous, handshaked fetch port and a byte-stream programming port. A loader (e.g. UART receiver) streams program bytes in; the block assembles them little-endian into instruction words and writes them sequentially from word 0. The block then serves byte-addressed PC fetches to the core's IF stage with one-cycle latency and flags misaligned and out-of-range fetches.

Parameters:
INSTRUCTION_WIDTH, 32, instruction word width in bits; must be a multiple of 8
MEMORY_DEPTH, 256, number of instruction words; power of 2, at least 2
PC_WIDTH, 32, width of the byte-address PC input
NOP_INSTRUCTION, 32'h00000013, word driven on a faulting fetch

Ports:
clk  input  1  system clock, all state on rising edge
rstN  input  1  asynchronous active-low reset
load_start  input  1  one-cycle pulse that begins or restarts programming
load_data  input  8  program byte
load_data_valid  input  1  load_data is valid this cycle
load_end  input  1  one-cycle pulse that ends programming
pc  input  PC_WIDTH  byte address of the fetch
fetch_req  input  1  fetch request
instruction  output  INSTRUCTION_WIDTH  fetched word
instruction_valid  output  1  instruction is valid this cycle
fetch_error  output  1  the fetch shown this cycle was misaligned or out of range
ready  output  1  memory is programmed and serving fetches
load_busy  output  1  programming is in progress
load_words  output  $clog2(MEMORY_DEPTH)+1  words written by the last or current load

Behaviour:
- Derived values: BYTES = INSTRUCTION_WIDTH/8; OFF = $clog2(BYTES); AW = $clog2(MEMORY_DEPTH); word index = pc >> OFF.
- Reset (asynchronous, rstN=0): state IDLE; instruction=0, instruction_valid=0, fetch_error=0, ready=0, load_busy=0, load_words=0; internal byte counter and assembly register cleared. Array contents are not reset.
- States: IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start.
  - LOAD -> RUN on load_end, or automatically after the word at index MEMORY_DEPTH-1 is written.
  - RUN -> LOAD on load_start.
  - load_start in LOAD restarts the load: counters clear, state stays LOAD.
- Entering LOAD clears load_words and the byte counter. load_busy=1 and ready=0 from the next cycle.
- LOAD byte handling:
  - Each load_data_valid byte goes into the assembly register at lane byte_cnt. The first byte lands in bits [7:0].
  - When byte_cnt==BYTES-1, the full word is written to mem[load_words] in the same edge, load_words increments, and byte_cnt returns to 0.
  - After the memory is full, further bytes are ignored.
- load_end in LOAD:
  - If load_data_valid is high in the same cycle, that byte is accepted first.
  - If a partial word remains (byte_cnt!=0), it is written zero-padded in the upper lanes and load_words increments.
  - Next state is RUN: ready=1, load_busy=0.
- load_end outside LOAD is ignored. load_start has priority over load_end in the same cycle.
- Words beyond load_words keep their previous contents.
- Fetch in RUN only, one-cycle latency. fetch_req=1 at edge N produces the following at edge N+1:
  - instruction_valid=1.
  - If pc[OFF-1:0]!=0 or word index >= MEMORY_DEPTH: fetch_error=1 and instruction=NOP_INSTRUCTION.
  - Otherwise: fetch_error=0 and instruction=mem[pc[OFF+AW-1:OFF]].
  - Back-to-back requests give one word per cycle.
- No request, or state not RUN: instruction_valid=0 and fetch_error=0 next cycle; instruction holds its last value.
- fetch_req in the same cycle as load_start: the load wins and no valid is produced.
- Read-during-write is not possible, because fetches are blocked in LOAD.
- Reset mid-load: all outputs return to reset values. The partially written array is retained but ready=0 until a new load completes.
- The array is a plain synchronous-read memory with a single write port, so it infers block RAM.

Test Plan:
- Reset, then load_start and bytes 13 00 00 00 93 00 10 00, then load_end -> load_words=2, ready=1 next cycle; fetch pc=0 then pc=4 back-to-back -> 0x00000013 then 0x00100093 on consecutive cycles, valid=1, error=0.
- Load 5 bytes AA BB CC DD EE with load_end in the same cycle as the 5th byte -> load_words=2; fetch pc=4 -> 0x000000EE.
- Fetch pc=2 -> valid=1, fetch_error=1, instruction=0x00000013. Fetch pc=0x400 with depth 256 -> same error response.
- Stream 1024+4 bytes without load_end -> auto RUN after the 256th word, extra bytes ignored, load_words=256; fetch pc=0x3FC returns the 256th word.
- Pulse load_start in RUN with fetch_req=1 in the same cycle -> no valid, load_busy=1 next cycle; reload 4 bytes -> word 0 replaced, word 1 unchanged from the earlier load.
- Assert rstN=0 midway through a word during LOAD -> ready=0, load_busy=0, load_words=0, valid=0 immediately; fetch_req afterwards gives no valid until the next completed load.
